multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: memory-wait cycles before fault; 0 disables timeout.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port opcode, input, 7: instr[6:0] from instruction register.
REQ-005 SHALL have port funct3, input, 3: instr[14:12].
REQ-006 SHALL have port funct7_5, input, 1: instr[30].
REQ-007 SHALL have port eq, input, 1: ALU equality flag.
REQ-008 SHALL have port mem_ready, input, 1: memory completes current access.
REQ-009 SHALL have port mem_req, output, 1: memory access request.
REQ-010 SHALL have port mem_we, output, 1: memory write, valid with mem_req.
REQ-011 SHALL have ports ir_we, pc_we, reg_we, output, 1 each: write strobes.
REQ-012 SHALL have ports adr_src (1), alu_src_a (2), alu_src_b (2), result_src (2), imm_src (3), alu_ctrl (3), all outputs: datapath selects.
REQ-013 SHALL have port fault, output, 1: sticky error flag.
REQ-014 SHALL have port instret, output, 32: retired-instruction count.

Function
REQ-015 SHALL implement states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, FAULT.
REQ-016 FETCH SHALL assert mem_req, adr_src=0; hold until mem_ready; on the mem_ready cycle pulse ir_we and pc_we (PC+4), go to DECODE.
REQ-017 DECODE SHALL compute branch target (alu_src_a=PC_old, alu_src_b=imm) and dispatch: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, other -> FAULT.
REQ-018 MEMADR SHALL go to MEMREAD for loads, MEMWRITE for stores.
REQ-019 MEMREAD/MEMWRITE SHALL assert mem_req with adr_src=1 (mem_we=1 in MEMWRITE) until mem_ready; MEMREAD -> MEMWB, MEMWRITE -> FETCH.
REQ-020 MEMWB, ALUWB SHALL pulse reg_we for exactly one cycle, then go to FETCH.
REQ-021 BRANCH SHALL use alu_ctrl=SUB; pc_we=1 iff (funct3=000 and eq) or (funct3=001 and !eq); funct3 otherwise -> FAULT; then FETCH.
REQ-022 JAL SHALL pulse pc_we (target) and reg_we (PC+4) together, then FETCH.
REQ-023 alu_ctrl in EXECR/EXECI SHALL be: ADD=000, SUB=001 (R-type funct7_5=1 only), AND=010, OR=011, SLT=101; unsupported funct3 -> FAULT.
REQ-024 Every instruction SHALL take 3-5 cycles plus memory wait cycles; minimum: ALU 4, load 5, store 4, branch 3, jal 3.
REQ-025 A timeout counter SHALL count consecutive cycles with mem_req=1 and mem_ready=0; reaching TIMEOUT_CYCLES SHALL enter FAULT.
REQ-026 FAULT SHALL assert fault=1, all strobes and mem_req 0, and stay until reset.
REQ-027 Strobes outside listed states SHALL be 0; no strobe SHALL assert in two consecutive cycles of the same state except mem_req.

Reset
REQ-028 rst=0 sampled at a clock edge SHALL force state FETCH, fault=0, timeout counter 0, instret 0, from any state incl. mid-access.
REQ-029 While rst=0, mem_req, mem_we, ir_we, pc_we, reg_we SHALL be 0; first cycle after release SHALL show mem_req=1 in FETCH.

Configuration
REQ-030 With INSTRET_CNT_EN defined, instret SHALL increment by 1 on each transition into FETCH from a non-FETCH, non-FAULT state, wrapping at 2^32.
REQ-031 Without INSTRET_CNT_EN, instret SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-032 Package riscv_pkg SHALL hold the state enum, opcode constants, alu_ctrl and imm_src encodings.
REQ-033 Sub-module alu_decoder SHALL map (state class, funct3, funct7_5) to alu_ctrl and illegal flag.

Verification
REQ-034 add x1,x2,x3 (0x003100B3), mem_ready=1 always -> reg_we one pulse in cycle 4, instret 0->1.
REQ-035 lw with mem_ready low 3 cycles in MEMREAD -> mem_req high 4 cycles, reg_we in MEMWB, TIMEOUT_CYCLES=16 no fault.
REQ-036 beq, eq=1 -> pc_we in cycle 3; eq=0 -> pc_we only in FETCH.
REQ-037 opcode 0x7F -> FAULT after DECODE, fault=1 stays; rst=0 one cycle -> fault=0, FETCH.
REQ-038 mem_ready held 0 in FETCH, TIMEOUT_CYCLES=16 -> fault=1 after 16 cycles; rst mid-MEMWRITE -> mem_we 0 and FETCH next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V control unit.
// Holds the controller state encoding, the RV32I opcodes the controller
// dispatches on, the alu_ctrl / imm_src encodings driven to the datapath,
// the datapath mux select codes, and the operation class handed to
// alu_decoder.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    FAULT    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  // ALU operand A: current PC, PC of the instruction in IR, register A
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  // ALU operand B: register B, immediate, constant 4
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  // Result bus: registered ALU output, memory read data, live ALU result
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // What the controller wants from the ALU in the current state
  typedef enum logic [1:0] {
    ALU_CLS_ADD = 2'd0,  // address / PC arithmetic
    ALU_CLS_SUB = 2'd1,  // branch compare
    ALU_CLS_R   = 2'd2,  // register-register op, decoded from funct3/funct7_5
    ALU_CLS_I   = 2'd3   // register-immediate op, decoded from funct3
  } alu_cls_t;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder.
// Maps the controller's operation class plus funct3/funct7_5 onto the
// alu_ctrl encoding and flags funct3 values the datapath does not support.
// Ports:
//   alu_cls   in  2  operation class (riscv_pkg::alu_cls_t encoding)
//   funct3    in  3  instr[14:12]
//   funct7_5  in  1  instr[30]
//   alu_ctrl  out 3  ALU operation select
//   illegal   out 1  unsupported R/I-type funct3
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

  alu_cls_t cls;
  assign cls = alu_cls_t'(alu_cls);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (cls)
      ALU_CLS_ADD: alu_ctrl = ALU_ADD;
      ALU_CLS_SUB: alu_ctrl = ALU_SUB;
      ALU_CLS_R, ALU_CLS_I: begin
        case (funct3)
          // bit 30 of an I-type word is immediate data, so only R-type subtracts
          3'b000:  alu_ctrl = (cls == ALU_CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: illegal  = 1'b1;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V (RV32I subset) control unit.
// Sequences fetch / decode / execute / memory / writeback for loads, stores,
// R- and I-type ALU ops, beq/bne and jal, and parks in a sticky FAULT state
// on an unsupported instruction or a memory access that never completes.
// Optional feature macro: INSTRET_CNT_EN -- adds the 32-bit retired
// instruction counter; without it instret is tied to 0.
// Ports:
//   clk, rst (sync, active-low)
//   opcode/funct3/funct7_5  instruction fields from IR
//   eq                      ALU zero flag
//   mem_ready               memory completes the current access
//   mem_req, mem_we         memory request / write
//   ir_we, pc_we, reg_we    write strobes
//   adr_src, alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl  selects
//   fault                   sticky error flag
//   instret                 retired instruction count
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        eq,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        adr_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [2:0]  imm_src,
  output logic [2:0]  alu_ctrl,
  output logic        fault,
  output logic [31:0] instret
);

  state_t   state_q, state_d;
  alu_cls_t alu_cls;
  logic     alu_illegal;
  logic     mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c;
  logic     timeout_hit;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  // ALU class depends on state only, so the illegal flag feeding back into
  // next-state logic does not form a combinational loop.
  always_comb begin
    alu_cls = ALU_CLS_ADD;
    case (state_q)
      EXECR:   alu_cls = ALU_CLS_R;
      EXECI:   alu_cls = ALU_CLS_I;
      BRANCH:  alu_cls = ALU_CLS_SUB;
      default: alu_cls = ALU_CLS_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_cls  (alu_cls),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_ctrl (alu_ctrl),
    .illegal  (alu_illegal)
  );

  always_comb begin
    state_d    = state_q;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    reg_we_c   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REG;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    case (state_q)
      FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // Branch / jump target into ALUOut while the opcode is dispatched
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXECR;
          OP_I:              state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          default:           state_d = FAULT;
        endcase
      end
      MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_we_c   = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXECR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        state_d   = alu_illegal ? FAULT : ALUWB;
      end
      EXECI: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        state_d   = alu_illegal ? FAULT : ALUWB;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_we_c   = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        // Compare rs1-rs2; ALUOut still holds the target from DECODE
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        result_src = RES_ALUOUT;
        state_d    = FETCH;
        case (funct3)
          3'b000:  pc_we_c = eq;
          3'b001:  pc_we_c = !eq;
          default: state_d = FAULT;
        endcase
      end
      JAL: begin
        // PC takes the target from ALUOut; the ALU meanwhile forms old PC + 4
        // which the datapath steers to rd in the same cycle.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_we_c    = 1'b1;
        reg_we_c   = 1'b1;
        state_d    = FETCH;
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
    // A stalled access never advances on its own, so this only overrides a hold
    if (timeout_hit) state_d = FAULT;
  end

  // Reset blanks every strobe immediately, even before the state register clears
  assign mem_req = mem_req_c & rst;
  assign mem_we  = mem_we_c  & rst;
  assign ir_we   = ir_we_c   & rst;
  assign pc_we   = pc_we_c   & rst;
  assign reg_we  = reg_we_c  & rst;
  assign fault   = (state_q == FAULT);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      logic [CNT_W-1:0] wait_cnt_q;
      logic             waiting;

      assign waiting     = mem_req_c && !mem_ready;
      // Counter holds the number of earlier consecutive wait cycles
      assign timeout_hit = waiting && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

      always_ff @(posedge clk) begin
        if (!rst)                         wait_cnt_q <= '0;
        else if (waiting && !timeout_hit) wait_cnt_q <= wait_cnt_q + 1'b1;
        else                              wait_cnt_q <= '0;
      end
    end
  endgenerate

`ifdef INSTRET_CNT_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (!rst)
      instret_q <= '0;
    else if (state_d == FETCH && state_q != FETCH && state_q != FAULT)
      instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        eq;
  logic        mem_ready;
  logic        mem_req, mem_we, ir_we, pc_we, reg_we;
  logic        adr_src;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  imm_src, alu_ctrl;
  logic        fault;
  logic [31:0] instret;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];

  multicycle_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .eq         (eq),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .reg_we     (reg_we),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .imm_src    (imm_src),
    .alu_ctrl   (alu_ctrl),
    .fault      (fault),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  // Strobe vector order: {mem_req, mem_we, ir_we, pc_we, reg_we, fault}
  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] FREQ  = 6'b100000;
  localparam logic [5:0] FDONE = 6'b101100;
  localparam logic [5:0] MRD   = 6'b100000;
  localparam logic [5:0] MWR   = 6'b110000;
  localparam logic [5:0] WB    = 6'b000010;
  localparam logic [5:0] PCW   = 6'b000100;
  localparam logic [5:0] JALS  = 6'b000110;
  localparam logic [5:0] FLT   = 6'b000001;

  typedef struct {
    string       nm;
    logic [5:0]  strb;
    logic        chk_alu;
    logic [2:0]  alu;
    logic        chk_adr;
    logic        adr;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_ret = 32'd0;

  // Monitor: one expected entry per cycle, compared mid-cycle
  initial begin
    exp_t       x;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x   = sb.pop_front();
        act = {mem_req, mem_we, ir_we, pc_we, reg_we, fault};
        checks++;
        if (act !== x.strb) begin
          errors++;
          $display("FAIL %s strobes act=%b exp=%b", x.nm, act, x.strb);
        end
        checks++;
        if (instret !== x.ret) begin
          errors++;
          $display("FAIL %s instret act=%0d exp=%0d", x.nm, instret, x.ret);
        end
        if (x.chk_alu) begin
          checks++;
          if (alu_ctrl !== x.alu) begin
            errors++;
            $display("FAIL %s alu_ctrl act=%b exp=%b", x.nm, alu_ctrl, x.alu);
          end
        end
        if (x.chk_adr) begin
          checks++;
          if (adr_src !== x.adr) begin
            errors++;
            $display("FAIL %s adr_src act=%b exp=%b", x.nm, adr_src, x.adr);
          end
        end
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic rdy, input logic e,
                      input logic [5:0] s, input logic ca, input logic [2:0] a,
                      input logic cadr, input logic ad);
    exp_t x;
    rst = r; mem_ready = rdy; eq = e;
    x.nm = nm; x.strb = s; x.chk_alu = ca; x.alu = a;
    x.chk_adr = cadr; x.adr = ad; x.ret = exp_ret;
    sb.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic plain(input string nm, input logic [5:0] s);
    step(nm, 1'b1, 1'b1, 1'b0, s, 1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic fetch(input string nm);
    step({nm, "/fetch"}, 1'b1, 1'b1, 1'b0, FDONE, 1'b1, 3'b000, 1'b1, 1'b0);
  endtask

  task automatic fetch_wait(input string nm, input int n);
    for (int i = 0; i < n; i++)
      step({nm, "/fwait"}, 1'b1, 1'b0, 1'b0, FREQ, 1'b0, 3'b000, 1'b1, 1'b0);
  endtask

  task automatic retire();
`ifdef INSTRET_CNT_EN
    exp_ret = exp_ret + 32'd1;
`endif
  endtask

  task automatic do_reset(input logic [5:0] s);
    step("reset", 1'b0, 1'b0, 1'b0, s, 1'b0, 3'b000, 1'b0, 1'b0);
    exp_ret = 32'd0;
  endtask

  task automatic alu_op(input string nm, input logic [31:0] ins, input logic [2:0] a);
    instr = ins;
    fetch(nm);
    plain({nm, "/decode"}, NONE);
    step({nm, "/exec"}, 1'b1, 1'b1, 1'b0, NONE, 1'b1, a, 1'b0, 1'b0);
    plain({nm, "/wb"}, WB);
    retire();
  endtask

  task automatic branch_op(input string nm, input logic [31:0] ins, input logic e,
                           input logic [5:0] s);
    instr = ins;
    fetch(nm);
    plain({nm, "/decode"}, NONE);
    step({nm, "/branch"}, 1'b1, 1'b1, e, s, 1'b1, 3'b001, 1'b0, 1'b0);
    retire();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mem_ready = 1'b1; eq = 1'b0; instr = 32'h0000_0013;
    repeat (2) @(posedge clk);
    #1;
    do_reset(NONE);

    alu_op("add",  32'h003100B3, 3'b000);
    alu_op("sub",  32'h403100B3, 3'b001);
    alu_op("and",  32'h003170B3, 3'b010);
    alu_op("or",   32'h003160B3, 3'b011);
    alu_op("slt",  32'h003120B3, 3'b101);
    alu_op("addi", 32'h00510093, 3'b000);
    alu_op("addi_b30", 32'h40010093, 3'b000);

    // lw with three wait cycles in MEMREAD
    instr = 32'h00012083;
    fetch_wait("lw", 2);
    fetch("lw");
    plain("lw/decode", NONE);
    step("lw/memadr", 1'b1, 1'b1, 1'b0, NONE, 1'b1, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("lw/mrd_wait", 1'b1, 1'b0, 1'b0, MRD, 1'b0, 3'b000, 1'b1, 1'b1);
    step("lw/mrd_done", 1'b1, 1'b1, 1'b0, MRD, 1'b0, 3'b000, 1'b1, 1'b1);
    plain("lw/memwb", WB);
    retire();

    // sw, no wait
    instr = 32'h00112023;
    fetch("sw");
    plain("sw/decode", NONE);
    plain("sw/memadr", NONE);
    step("sw/mwr", 1'b1, 1'b1, 1'b0, MWR, 1'b0, 3'b000, 1'b1, 1'b1);
    retire();

    branch_op("beq_taken", 32'h00208463, 1'b1, PCW);
    branch_op("beq_nt",    32'h00208463, 1'b0, NONE);
    branch_op("bne_taken", 32'h00209463, 1'b0, PCW);
    branch_op("bne_nt",    32'h00209463, 1'b1, NONE);

    instr = 32'h008000EF;
    fetch("jal");
    plain("jal/decode", NONE);
    plain("jal/jal", JALS);
    retire();

    // Illegal opcode: FAULT after DECODE, sticky, cleared by one reset cycle
    instr = 32'h0000007F;
    fetch("ill");
    plain("ill/decode", NONE);
    for (int i = 0; i < 3; i++)
      step("ill/fault", 1'b1, i[0], 1'b0, FLT, 1'b0, 3'b000, 1'b0, 1'b0);
    do_reset(FLT);
    alu_op("add_after_rst", 32'h003100B3, 3'b000);

    // Unsupported R-type funct3 (sll)
    instr = 32'h003110B3;
    fetch("sll");
    plain("sll/decode", NONE);
    plain("sll/exec", NONE);
    plain("sll/fault", FLT);
    do_reset(FLT);

    // Unsupported branch funct3 (blt)
    instr = 32'h0020C463;
    fetch("blt");
    plain("blt/decode", NONE);
    plain("blt/branch", NONE);
    plain("blt/fault", FLT);
    do_reset(FLT);

    // Fetch timeout: 16 wait cycles, then FAULT
    fetch_wait("tmo", 16);
    step("tmo/fault", 1'b1, 1'b0, 1'b0, FLT, 1'b0, 3'b000, 1'b0, 1'b0);
    step("tmo/fault2", 1'b1, 1'b1, 1'b0, FLT, 1'b0, 3'b000, 1'b0, 1'b0);
    do_reset(FLT);

    // Reset in the middle of a stalled store
    instr = 32'h00112023;
    fetch("sw_rst");
    plain("sw_rst/decode", NONE);
    plain("sw_rst/memadr", NONE);
    step("sw_rst/mwr_wait", 1'b1, 1'b0, 1'b0, MWR, 1'b0, 3'b000, 1'b1, 1'b1);
    do_reset(NONE);
    fetch_wait("sw_rst_after", 1);
    alu_op("add_final", 32'h003100B3, 3'b000);
    instr = 32'h00000013;
    step("idle_fetch", 1'b1, 1'b0, 1'b0, FREQ, 1'b0, 3'b000, 1'b1, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain act=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
